lcd_bus_receiver: RTL and testbench

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

---
 rtl/lcd_bus_receiver.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// 16-bit 8080-style LCD write bus receiver: synchronizes the bus, decodes panel commands
// and streams RAMWR pixels out. Optional RDID read-back is enabled with LCD_RX_RDID_EN.
module lcd_bus_receiver #(
    parameter int unsigned X_SIZE = 480,
    parameter int unsigned Y_SIZE = 800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_cs,
    input  logic        lcd_rs,
    input  logic        lcd_wr,
    input  logic        lcd_rd,
    input  logic [15:0] lcd_data_i,
    output logic [15:0] lcd_data_o,
    output logic        lcd_data_oe,
    output logic        pix_we,
    output logic [18:0] pix_addr,
    output logic [15:0] pix_data,
    output logic        sleep_out,
    output logic        display_on,
    output logic [7:0]  colmod,
    output logic        frame_done,
    output logic        cmd_err
);

    localparam int unsigned FS        = X_SIZE * Y_SIZE;
    localparam logic [18:0] LAST_ADDR = 19'(FS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLMOD_ARG,
        RAMWR,
        RDID
    } state_t;

    state_t state, state_n;

    logic        cs_s1, cs_s2, rs_s1, rs_s2, wr_s1, wr_s2, rd_s1, rd_s2;
    logic [15:0] data_s1, data_s2;
    logic        wr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            rs_s1   <= 1'b0;
            rs_s2   <= 1'b0;
            wr_s1   <= 1'b1;
            wr_s2   <= 1'b1;
            rd_s1   <= 1'b1;
            rd_s2   <= 1'b1;
            data_s1 <= '0;
            data_s2 <= '0;
            wr_d    <= 1'b1;
        end else begin
            cs_s1   <= lcd_cs;
            cs_s2   <= cs_s1;
            rs_s1   <= lcd_rs;
            rs_s2   <= rs_s1;
            wr_s1   <= lcd_wr;
            wr_s2   <= wr_s1;
            rd_s1   <= lcd_rd;
            rd_s2   <= rd_s1;
            data_s1 <= lcd_data_i;
            data_s2 <= data_s1;
            wr_d    <= wr_s2;
        end
    end

    logic       wr_evt, cmd_evt, dat_evt;
    logic [7:0] opcode;

    // rs and data come from the same stage as wr, so they are stable at the detected edge
    assign wr_evt  = wr_s2 & ~wr_d & ~cs_s2;
    assign cmd_evt = wr_evt & ~rs_s2;
    assign dat_evt = wr_evt & rs_s2;
    assign opcode  = data_s2[15:8];

    // addr_cnt is the next pixel slot; pix_addr reports the slot of the current pix_we
    logic [18:0] addr_cnt, addr_cnt_n, pix_addr_n;
    logic [15:0] pix_data_n;
    logic [7:0]  colmod_n;
    logic        pix_we_n, frame_done_n, cmd_err_n, sleep_n, disp_n;

    always_comb begin
        state_n      = state;
        addr_cnt_n   = addr_cnt;
        pix_addr_n   = pix_addr;
        pix_data_n   = pix_data;
        colmod_n     = colmod;
        sleep_n      = sleep_out;
        disp_n       = display_on;
        pix_we_n     = 1'b0;
        frame_done_n = 1'b0;
        cmd_err_n    = 1'b0;
        if (cmd_evt) begin
            state_n = IDLE;
            case (opcode)
                8'h00: ;
                8'h11: sleep_n = 1'b1;
                8'h10: sleep_n = 1'b0;
                8'h29: disp_n  = 1'b1;
                8'h28: disp_n  = 1'b0;
                8'h3A: state_n = COLMOD_ARG;
                8'h2C: begin
                    addr_cnt_n = '0;
                    pix_addr_n = '0;
                    state_n    = RAMWR;
                end
                8'h3C: state_n = RAMWR;
`ifdef LCD_RX_RDID_EN
                8'h04: state_n = RDID;
`endif
                default: cmd_err_n = 1'b1;
            endcase
        end else if (dat_evt) begin
            case (state)
                COLMOD_ARG: begin
                    colmod_n = data_s2[7:0];
                    state_n  = IDLE;
                end
                RAMWR: begin
                    pix_we_n   = 1'b1;
                    pix_data_n = data_s2;
                    pix_addr_n = addr_cnt;
                    if (addr_cnt == LAST_ADDR) begin
                        addr_cnt_n   = '0;
                        frame_done_n = 1'b1;
                    end else begin
                        addr_cnt_n = addr_cnt + 19'd1;
                    end
                end
                default: cmd_err_n = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            pix_addr   <= '0;
            pix_data   <= '0;
            colmod     <= '0;
            sleep_out  <= 1'b0;
            display_on <= 1'b0;
            pix_we     <= 1'b0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_n;
            addr_cnt   <= addr_cnt_n;
            pix_addr   <= pix_addr_n;
            pix_data   <= pix_data_n;
            colmod     <= colmod_n;
            sleep_out  <= sleep_n;
            display_on <= disp_n;
            pix_we     <= pix_we_n;
            frame_done <= frame_done_n;
            cmd_err    <= cmd_err_n;
        end
    end

`ifdef LCD_RX_RDID_EN
    logic        rd_d;
    logic [1:0]  rd_idx;
    logic [15:0] rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d   <= 1'b1;
            rd_idx <= '0;
        end else begin
            rd_d <= rd_s2;
            if (cmd_evt || state != RDID)
                rd_idx <= '0;
            else if (rd_s2 && !rd_d && !cs_s2 && rd_idx != 2'd3)
                rd_idx <= rd_idx + 2'd1;
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            2'd0: rd_word = 16'h0000;
            2'd1: rd_word = 16'h0054;
            2'd2: rd_word = 16'h0080;
            2'd3: rd_word = 16'h0066;
            default: rd_word = '0;
        endcase
    end

    assign lcd_data_oe = (state == RDID) & ~cs_s2 & ~rd_s2;
    assign lcd_data_o  = lcd_data_oe ? rd_word : '0;
`else
    logic unused_rd;
    assign unused_rd   = rd_s2;
    assign lcd_data_oe = 1'b0;
    assign lcd_data_o  = '0;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver (4x2 panel): vector table of bus writes with a scoreboard of
// expected pix_we/cmd_err events checked for content and 3-cycle latency, plus reset/RDID sequences.
module tb_lcd_bus_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lcd_cs = 1'b1, lcd_rs = 1'b0, lcd_wr = 1'b1, lcd_rd = 1'b1;
    logic [15:0] lcd_data_i = '0;
    logic [15:0] lcd_data_o;
    logic        lcd_data_oe, pix_we, sleep_out, display_on, frame_done, cmd_err;
    logic [18:0] pix_addr;
    logic [15:0] pix_data;
    logic [7:0]  colmod;

    lcd_bus_receiver #(.X_SIZE(4), .Y_SIZE(2)) dut (
        .clk(clk), .rst(rst), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr),
        .lcd_rd(lcd_rd), .lcd_data_i(lcd_data_i), .lcd_data_o(lcd_data_o),
        .lcd_data_oe(lcd_data_oe), .pix_we(pix_we), .pix_addr(pix_addr),
        .pix_data(pix_data), .sleep_out(sleep_out), .display_on(display_on),
        .colmod(colmod), .frame_done(frame_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        cs, rs;
        logic [15:0] data;
        logic        we, err;
        logic [18:0] addr;
        logic        fd, sleep, disp;
        logic [7:0]  col;
    } vec_t;

    typedef struct {
        logic        we, err;
        logic [18:0] addr;
        logic [15:0] data;
        logic        fd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic cs, logic rs, logic [15:0] data, logic we, logic err,
                                logic [18:0] addr, logic fd, logic sleep, logic disp,
                                logic [7:0] col);
        vec_t v;
        v.cs = cs; v.rs = rs; v.data = data; v.we = we; v.err = err; v.addr = addr;
        v.fd = fd; v.sleep = sleep; v.disp = disp; v.col = col;
        return v;
    endfunction

    // Event monitor: every pix_we/cmd_err must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (pix_we || cmd_err)) begin
            chk("we_err_exclusive", 32'(pix_we & cmd_err), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: got we=%b err=%b addr=%0d, expected no event",
                         pix_we, cmd_err, pix_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ev_we", 32'(pix_we), 32'(e.we));
                chk("ev_err", 32'(cmd_err), 32'(e.err));
                chk("ev_frame_done", 32'(frame_done), 32'(e.fd));
                chk("ev_latency", 32'(cyc), 32'(e.cyc));
                if (e.we) begin
                    chk("ev_addr", 32'(pix_addr), 32'(e.addr));
                    chk("ev_data", 32'(pix_data), 32'(e.data));
                end
            end
        end
    end

    // Pins change just after a falling edge; the pix_we/cmd_err event is due 3 rising edges
    // after the wr rise, and the queue must be drained before the next write.
    task automatic bus_write(input logic cs, input logic rs, input logic [15:0] data,
                             input logic we, input logic err, input logic [18:0] addr,
                             input logic fd);
        exp_t e;
        lcd_cs = cs; lcd_rs = rs; lcd_data_i = data; lcd_wr = 1'b0;
        repeat (2) @(negedge clk);
        if (we || err) begin
            e.we = we; e.err = err; e.addr = addr; e.data = data; e.fd = fd; e.cyc = cyc + 3;
            exp_q.push_back(e);
        end
        lcd_wr = 1'b1;
        repeat (5) @(negedge clk);
        chk("event_drained", 32'(exp_q.size()), 0);
        lcd_cs = 1'b1;
    endtask

    task automatic rd_pulse(input logic [15:0] exp_word, input logic exp_oe);
        lcd_cs = 1'b0;
        lcd_rd = 1'b0;
        repeat (3) @(negedge clk);
        chk("rd_oe_low", 32'(lcd_data_oe), 32'(exp_oe));
        chk("rd_data", 32'(lcd_data_o), 32'(exp_word));
        lcd_rd = 1'b1;
        repeat (3) @(negedge clk);
        chk("rd_oe_high", 32'(lcd_data_oe), 0);
        lcd_cs = 1'b1;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({pix_we, frame_done, cmd_err, sleep_out, display_on, lcd_data_oe}), 0);
        chk({name, "_addr"}, 32'(pix_addr), 0);
        chk({name, "_data"}, 32'({pix_data, colmod}), 0);
        chk({name, "_rdo"}, 32'(lcd_data_o), 0);
    endtask

    logic rdid_err;

    initial begin
`ifdef LCD_RX_RDID_EN
        rdid_err = 1'b0;
`else
        rdid_err = 1'b1;
`endif
        //             cs   rs    data     we   err  addr fd  slp  dsp  colmod
        tbl.push_back(mk(0, 0, 16'h1100, 0, 0, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 16'h3A00, 0, 0, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 1, 16'h0055, 0, 0, 0, 0, 1, 0, 8'h55));
        tbl.push_back(mk(0, 0, 16'h2900, 0, 0, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 0, 16'h2C00, 0, 0, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'hF800, 1, 0, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'h07E0, 1, 0, 1, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'h001F, 1, 0, 2, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 0, 16'h3C00, 0, 0, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'h1234, 1, 0, 3, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'h1111, 1, 0, 4, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'h2222, 1, 0, 5, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'h3333, 1, 0, 6, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'h4444, 1, 0, 7, 1, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'h5555, 1, 0, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(1, 1, 16'hAAAA, 0, 0, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(1, 0, 16'h1000, 0, 0, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 0, 16'h5500, 0, 1, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'h0001, 0, 1, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 1, 16'h0002, 0, 1, 0, 0, 1, 1, 8'h55));
        tbl.push_back(mk(0, 0, 16'h2800, 0, 0, 0, 0, 1, 0, 8'h55));
        tbl.push_back(mk(0, 0, 16'h1000, 0, 0, 0, 0, 0, 0, 8'h55));
        tbl.push_back(mk(0, 0, 16'h0400, 0, rdid_err, 0, 0, 0, 0, 8'h55));
        tbl.push_back(mk(0, 0, 16'h3A00, 0, 0, 0, 0, 0, 0, 8'h55));
        tbl.push_back(mk(0, 1, 16'h00AB, 0, 0, 0, 0, 0, 0, 8'hAB));
        tbl.push_back(mk(0, 0, 16'h3A00, 0, 0, 0, 0, 0, 0, 8'hAB));
        tbl.push_back(mk(0, 0, 16'h2900, 0, 0, 0, 0, 0, 1, 8'hAB));
        tbl.push_back(mk(0, 1, 16'h0077, 0, 1, 0, 0, 0, 1, 8'hAB));

        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        foreach (tbl[i]) begin
            bus_write(tbl[i].cs, tbl[i].rs, tbl[i].data, tbl[i].we, tbl[i].err,
                      tbl[i].addr, tbl[i].fd);
            chk($sformatf("v%0d_sleep", i), 32'(sleep_out), 32'(tbl[i].sleep));
            chk($sformatf("v%0d_disp", i), 32'(display_on), 32'(tbl[i].disp));
            chk($sformatf("v%0d_colmod", i), 32'(colmod), 32'(tbl[i].col));
        end

        // Reset in the middle of a pending pixel write
        bus_write(0, 0, 16'h1100, 0, 0, 0, 0);
        bus_write(0, 0, 16'h2C00, 0, 0, 0, 0);
        bus_write(0, 1, 16'hBEEF, 1, 0, 0, 0);
        bus_write(0, 1, 16'hCAFE, 1, 0, 1, 0);
        lcd_cs = 1'b0; lcd_rs = 1'b1; lcd_data_i = 16'h0F0F; lcd_wr = 1'b0;
        repeat (2) @(negedge clk);
        lcd_wr = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        repeat (3) @(negedge clk);
        chk_all_zero("mid_reset_hold");
        lcd_cs = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus_write(0, 1, 16'h1357, 0, 1, 0, 0);
        bus_write(0, 0, 16'h3C00, 0, 0, 0, 0);
        bus_write(0, 1, 16'h2468, 1, 0, 0, 0);

        // Read-back of the display ID
        bus_write(0, 0, 16'h0400, 0, rdid_err, 0, 0);
`ifdef LCD_RX_RDID_EN
        rd_pulse(16'h0000, 1'b1);
        rd_pulse(16'h0054, 1'b1);
        rd_pulse(16'h0080, 1'b1);
        rd_pulse(16'h0066, 1'b1);
        rd_pulse(16'h0066, 1'b1);
`else
        rd_pulse(16'h0000, 1'b0);
        rd_pulse(16'h0000, 1'b0);
`endif

        repeat (5) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
